// File: rtl/bitblaster_pkg.sv
// ---------------------------------------------------------------------------
// bitblaster_pkg
// Shared definitions for the 10-bit processor control path:
//   - opcode_e   : 4-bit instruction opcodes (0000-0111 defined, rest undefined)
//   - alu_op_e   : 3-bit ALU operation codes driven on ALUcont
//   - tstep_e    : the four timesteps T0-T3
//   - instruction field bit positions
//   - helpers: one-hot register select, ALU-op classification and mapping
// ---------------------------------------------------------------------------
package bitblaster_pkg;

    typedef enum logic [3:0] {
        OP_LD  = 4'b0000,
        OP_MOV = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_AND = 4'b0100,
        OP_OR  = 4'b0101,
        OP_XOR = 4'b0110,
        OP_NOT = 4'b0111
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    // Instruction word layout: [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] unused.
    localparam int INSTR_W = 10;
    localparam int OP_MSB  = 9;
    localparam int OP_LSB  = 6;
    localparam int RX_MSB  = 5;
    localparam int RX_LSB  = 4;
    localparam int RY_MSB  = 3;
    localparam int RY_LSB  = 2;

    // Register index to one-hot select for the four general registers.
    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        logic [3:0] sel;
        sel      = 4'b0000;
        sel[idx] = 1'b1;
        return sel;
    endfunction

    // Opcodes that run the three-step A/G ALU sequence.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

    function automatic logic [2:0] alu_code(input logic [3:0] op);
        logic [2:0] code;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            OP_XOR:  code = ALU_XOR;
            OP_NOT:  code = ALU_NOT;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/instr_sequencer_tstep_counter.sv
// ---------------------------------------------------------------------------
// tstep_counter
// 2-bit timestep counter, updated on the falling edge of CLKb.
// Ports:
//   CLKb      in  clock (falling edge active)
//   CLRb      in  asynchronous active-low reset -> count = 0
//   i_clear   in  synchronous clear (wins over enable)
//   i_enable  in  synchronous count enable
//   o_count   out current count
// ---------------------------------------------------------------------------
module tstep_counter (
    input  logic       CLKb,
    input  logic       CLRb,
    input  logic       i_clear,
    input  logic       i_enable,
    output logic [1:0] o_count
);

    logic [1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(negedge CLKb or negedge CLRb) begin
        if (!CLRb) begin
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_count <= 2'd0;
        end else if (i_enable) begin
            r_count <= r_count + 2'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Control unit for the 10-bit processor. Latches an instruction in T0 when
// Run is high, steps it through T1-T3 and decodes (timestep, IR) into the
// register-file, bus and ALU strobes. All state changes on the falling edge.
//
// Ports:
//   CLKb     in   clock, falling edge active
//   CLRb     in   asynchronous active-low reset
//   Run      in   start request, sampled only in T0
//   INSTR    in   instruction word {opcode[3:0], Rx[1:0], Ry[1:0], 2'bxx}
//   IRin     out  IR load strobe (= Run in T0)
//   Rin      out  one-hot register write enable
//   Rout     out  one-hot register bus drive
//   ExtOut   out  external data drives the bus
//   Ain      out  A register load
//   Gin      out  G register load
//   Gout     out  G drives the bus
//   ALUcont  out  ALU operation (0 whenever Gin is low)
//   Done     out  last timestep of the current instruction
//   Tstep    out  current timestep (debug)
//   ILL      out  undefined opcode trap, only when
//                 INSTR_SEQUENCER_ILLEGAL_TRAP_EN is defined
//
// Configuration macro: INSTR_SEQUENCER_ILLEGAL_TRAP_EN
// ---------------------------------------------------------------------------
module instr_sequencer
    import bitblaster_pkg::*;
#(
    // Fixed at 4: the register fields are 2 bits wide.
    parameter int NREG = 4
) (
    input  logic                CLKb,
    input  logic                CLRb,
    input  logic                Run,
    input  logic [INSTR_W-1:0]  INSTR,
    output logic                IRin,
    output logic [NREG-1:0]     Rin,
    output logic [NREG-1:0]     Rout,
    output logic                ExtOut,
    output logic                Ain,
    output logic                Gin,
    output logic                Gout,
    output logic [2:0]          ALUcont,
    output logic                Done,
    output logic [1:0]          Tstep
`ifdef INSTR_SEQUENCER_ILLEGAL_TRAP_EN
    ,
    output logic                ILL
`endif
);

    logic [INSTR_W-1:0] r_ir;
    logic [1:0]         w_t;
    logic               w_enable;
    logic [3:0]         w_op;
    logic [1:0]         w_rx;
    logic [1:0]         w_ry;
    logic               w_ill;
    logic               w_unused;

    // -----------------------------------------------------------------------
    // Timestep counter: Done returns to T0, otherwise advance outside T0 or
    // on a Run fetch. T3 without Done cannot occur for defined opcodes.
    // -----------------------------------------------------------------------
    assign w_enable = (w_t != T0) | Run;

    tstep_counter u_tstep (
        .CLKb     (CLKb),
        .CLRb     (CLRb),
        .i_clear  (Done),
        .i_enable (w_enable),
        .o_count  (w_t)
    );

    // -----------------------------------------------------------------------
    // Instruction register: loads only on the T0 fetch edge, so it stays
    // stable for the whole instruction regardless of INSTR/Run activity.
    // -----------------------------------------------------------------------
    always_ff @(negedge CLKb or negedge CLRb) begin
        if (!CLRb) begin
            r_ir <= '0;
        end else if (IRin) begin
            r_ir <= INSTR;
        end
    end

    assign w_op = r_ir[OP_MSB:OP_LSB];
    assign w_rx = r_ir[RX_MSB:RX_LSB];
    assign w_ry = r_ir[RY_MSB:RY_LSB];

    // -----------------------------------------------------------------------
    // Control decode. Only one of Rout/ExtOut/Gout is set in any arm, which
    // keeps the shared bus single-driver.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case statements leaves a signal unassigned (no latch inferred).
        IRin    = 1'b0;
        Rin     = '0;
        Rout    = '0;
        ExtOut  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        ALUcont = ALU_ADD;
        Done    = 1'b0;
        w_ill   = 1'b0;

        case (w_t)
            T0: begin
                IRin = Run;
            end

            T1: begin
                case (w_op)
                    OP_LD: begin
                        ExtOut = 1'b1;
                        Rin    = reg_onehot(w_rx);
                        Done   = 1'b1;
                    end
                    OP_MOV: begin
                        Rout = reg_onehot(w_ry);
                        Rin  = reg_onehot(w_rx);
                        Done = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                        Rout = reg_onehot(w_rx);
                        Ain  = 1'b1;
                    end
                    default: begin
                        // Undefined opcode: single-step NOP.
                        Done  = 1'b1;
                        w_ill = 1'b1;
                    end
                endcase
            end

            T2: begin
                if (is_alu_op(w_op)) begin
                    Gin     = 1'b1;
                    ALUcont = alu_code(w_op);
                    // NOT is unary: the bus stays undriven this step.
                    if (w_op != OP_NOT) begin
                        Rout = reg_onehot(w_ry);
                    end
                end
            end

            T3: begin
                if (is_alu_op(w_op)) begin
                    Gout = 1'b1;
                    Rin  = reg_onehot(w_rx);
                    Done = 1'b1;
                end
            end

            default: ;
        endcase
    end

    assign Tstep = w_t;

`ifdef INSTR_SEQUENCER_ILLEGAL_TRAP_EN
    assign ILL      = w_ill;
    assign w_unused = ^r_ir[1:0];
`else
    assign w_unused = ^{r_ir[1:0], w_ill};
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Self-checking bench for instr_sequencer: table-driven instruction vectors,
// a hand-written mid-instruction reset sequence and a random instruction
// stream checked against a behavioural model through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

`ifdef INSTR_SEQUENCER_ILLEGAL_TRAP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic       irin;
        logic [3:0] rin;
        logic [3:0] rout;
        logic       ext;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [2:0] alu;
        logic       done;
        logic [1:0] tstep;
        logic       ill;
    } exp_t;

    typedef struct {
        string      name;
        logic       run;
        logic [9:0] instr;
        exp_t       e;
    } vec_t;

    logic       CLKb;
    logic       CLRb;
    logic       Run;
    logic [9:0] INSTR;
    logic       IRin;
    logic [3:0] Rin;
    logic [3:0] Rout;
    logic       ExtOut;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic [2:0] ALUcont;
    logic       Done;
    logic [1:0] Tstep;
    logic       w_ill;

    instr_sequencer #(.NREG(4)) dut (
        .CLKb    (CLKb),
        .CLRb    (CLRb),
        .Run     (Run),
        .INSTR   (INSTR),
        .IRin    (IRin),
        .Rin     (Rin),
        .Rout    (Rout),
        .ExtOut  (ExtOut),
        .Ain     (Ain),
        .Gin     (Gin),
        .Gout    (Gout),
        .ALUcont (ALUcont),
        .Done    (Done),
        .Tstep   (Tstep)
`ifdef INSTR_SEQUENCER_ILLEGAL_TRAP_EN
        ,
        .ILL     (w_ill)
`endif
    );

`ifndef INSTR_SEQUENCER_ILLEGAL_TRAP_EN
    assign w_ill = 1'b0;
`endif

    initial begin
        CLKb = 1'b1;
        forever #5 CLKb = ~CLKb;
    end

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    // Model state.
    logic [1:0] m_t;
    logic [9:0] m_ir;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic exp_t mk(input logic irin, input logic [3:0] rin, input logic [3:0] rout,
                                input logic ext, input logic ain, input logic gin, input logic gout,
                                input logic [2:0] alu, input logic done, input logic [1:0] t,
                                input logic ill);
        exp_t e;
        e.irin = irin; e.rin = rin; e.rout = rout; e.ext = ext; e.ain = ain;
        e.gin = gin; e.gout = gout; e.alu = alu; e.done = done; e.tstep = t; e.ill = ill;
        return e;
    endfunction

    // Behavioural model of the decode, written from the instruction table.
    function automatic exp_t model(input logic [1:0] t, input logic [9:0] ir, input logic run);
        exp_t       e;
        logic [3:0] op;
        logic [3:0] rx_sel;
        logic [3:0] ry_sel;
        e      = '0;
        e.tstep = t;
        op     = ir[9:6];
        rx_sel = 4'b0001 << ir[5:4];
        ry_sel = 4'b0001 << ir[3:2];
        if (t == 2'd0) begin
            e.irin = run;
        end else if (op[3]) begin
            if (t == 2'd1) begin
                e.done = 1'b1;
                e.ill  = ILL_EN;
            end
        end else if (op == 4'd0) begin
            if (t == 2'd1) begin
                e.ext = 1'b1; e.rin = rx_sel; e.done = 1'b1;
            end
        end else if (op == 4'd1) begin
            if (t == 2'd1) begin
                e.rout = ry_sel; e.rin = rx_sel; e.done = 1'b1;
            end
        end else begin
            if (t == 2'd1) begin
                e.rout = rx_sel; e.ain = 1'b1;
            end else if (t == 2'd2) begin
                e.gin = 1'b1;
                e.alu = 3'(op - 4'd2);
                if (op != 4'd7) e.rout = ry_sel;
            end else begin
                e.gout = 1'b1; e.rin = rx_sel; e.done = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic exp_t get_act();
        return mk(IRin, Rin, Rout, ExtOut, Ain, Gin, Gout, ALUcont, Done, Tstep, w_ill);
    endfunction

    // One timestep: drive, push expectation, compare mid-period, then take
    // the falling edge and advance the model.
    task automatic do_step(input string name, input logic run, input logic [9:0] instr,
                           input exp_t e);
        exp_t act;
        exp_t want;
        exp_t m_e;
        int   nbus;
        Run   = run;
        INSTR = instr;
        sb_q.push_back(e);
        #2;
        act  = get_act();
        want = sb_q.pop_front();
        check(name, 32'(act), 32'(want));
        nbus = $countones({Rout, ExtOut, Gout});
        check({name, "_bus"}, 32'((nbus <= 1) && !(Tstep == 2'd3 && !Done)), 32'd1);
        m_e = model(m_t, m_ir, run);
        @(negedge CLKb);
        #1;
        if (m_e.done) begin
            m_t = 2'd0;
        end else if (m_t != 2'd0 || run) begin
            if (m_t == 2'd0) m_ir = instr;
            m_t = m_t + 2'd1;
        end
    endtask

    task automatic step_model(input string name, input logic run, input logic [9:0] instr);
        do_step(name, run, instr, model(m_t, m_ir, run));
    endtask

    task automatic add_vec(input string name, input logic run, input logic [9:0] instr,
                           input exp_t e);
        vec_t v;
        v.name = name; v.run = run; v.instr = instr; v.e = e;
        vecs.push_back(v);
    endtask

    initial begin
        int n_instr;
        int steps;
        logic [9:0] r_instr;
        logic       r_run;

        m_t  = 2'd0;
        m_ir = 10'd0;

        // --- vector table -------------------------------------------------
        // LD R2
        add_vec("ld_t0",   1'b1, 10'b0000_10_00_00, mk(1,4'b0000,4'b0000,0,0,0,0,3'd0,0,2'd0,0));
        add_vec("ld_t1",   1'b0, 10'b0000_10_00_00, mk(0,4'b0100,4'b0000,1,0,0,0,3'd0,1,2'd1,0));
        add_vec("ld_idle", 1'b0, 10'b0000_10_00_00, mk(0,4'b0000,4'b0000,0,0,0,0,3'd0,0,2'd0,0));
        // SUB R1,R3
        add_vec("sub_t0",  1'b1, 10'b0011_01_11_00, mk(1,4'b0000,4'b0000,0,0,0,0,3'd0,0,2'd0,0));
        add_vec("sub_t1",  1'b0, 10'b0011_01_11_00, mk(0,4'b0000,4'b0010,0,1,0,0,3'd0,0,2'd1,0));
        add_vec("sub_t2",  1'b0, 10'b0011_01_11_00, mk(0,4'b0000,4'b1000,0,0,1,0,3'd1,0,2'd2,0));
        add_vec("sub_t3",  1'b0, 10'b0011_01_11_00, mk(0,4'b0010,4'b0000,0,0,0,1,3'd0,1,2'd3,0));
        add_vec("sub_idle",1'b0, 10'b0011_01_11_00, mk(0,4'b0000,4'b0000,0,0,0,0,3'd0,0,2'd0,0));
        // Undefined opcode 1010
        add_vec("ill_t0",  1'b1, 10'b1010_01_10_00, mk(1,4'b0000,4'b0000,0,0,0,0,3'd0,0,2'd0,0));
        add_vec("ill_t1",  1'b0, 10'b1010_01_10_00, mk(0,4'b0000,4'b0000,0,0,0,0,3'd0,1,2'd1,ILL_EN));
        add_vec("ill_idle",1'b0, 10'b1010_01_10_00, mk(0,4'b0000,4'b0000,0,0,0,0,3'd0,0,2'd0,0));
        // MOV R1,R1
        add_vec("mov_t0",  1'b1, 10'b0001_01_01_00, mk(1,4'b0000,4'b0000,0,0,0,0,3'd0,0,2'd0,0));
        add_vec("mov_t1",  1'b0, 10'b0001_01_01_00, mk(0,4'b0010,4'b0010,0,0,0,0,3'd0,1,2'd1,0));
        add_vec("mov_idle",1'b0, 10'b0001_01_01_00, mk(0,4'b0000,4'b0000,0,0,0,0,3'd0,0,2'd0,0));
        // XOR R3,R0 with Run/INSTR toggling mid-instruction, then LD R0 back-to-back
        add_vec("xor_t0",  1'b1, 10'b0110_11_00_00, mk(1,4'b0000,4'b0000,0,0,0,0,3'd0,0,2'd0,0));
        add_vec("xor_t1",  1'b1, 10'b0001_00_01_00, mk(0,4'b0000,4'b1000,0,1,0,0,3'd0,0,2'd1,0));
        add_vec("xor_t2",  1'b0, 10'b1111_10_10_11, mk(0,4'b0000,4'b0001,0,0,1,0,3'd4,0,2'd2,0));
        add_vec("xor_t3",  1'b1, 10'b0000_00_00_00, mk(0,4'b1000,4'b0000,0,0,0,1,3'd0,1,2'd3,0));
        add_vec("b2b_t0",  1'b1, 10'b0000_00_00_00, mk(1,4'b0000,4'b0000,0,0,0,0,3'd0,0,2'd0,0));
        add_vec("b2b_t1",  1'b0, 10'b0111_11_11_11, mk(0,4'b0001,4'b0000,1,0,0,0,3'd0,1,2'd1,0));
        add_vec("b2b_idle",1'b0, 10'b0111_11_11_11, mk(0,4'b0000,4'b0000,0,0,0,0,3'd0,0,2'd0,0));

        // --- reset state --------------------------------------------------
        CLRb  = 1'b0;
        Run   = 1'b0;
        INSTR = 10'b0010_01_10_00;
        #2;
        check("rst_outputs", 32'(get_act()), 32'(mk(0,4'b0,4'b0,0,0,0,0,3'd0,0,2'd0,0)));
        Run = 1'b1;
        #1;
        check("rst_irin_run", 32'(get_act()), 32'(mk(1,4'b0,4'b0,0,0,0,0,3'd0,0,2'd0,0)));
        Run = 1'b0;
        @(negedge CLKb);
        #1;
        CLRb = 1'b1;
        @(negedge CLKb);
        #1;

        // --- table-driven vectors ----------------------------------------
        foreach (vecs[i]) begin
            do_step(vecs[i].name, vecs[i].run, vecs[i].instr, vecs[i].e);
        end

        // --- reset in T2 of ADD ------------------------------------------
        step_model("add_t0", 1'b1, 10'b0010_01_10_00);
        step_model("add_t1", 1'b0, 10'b0010_01_10_00);
        CLRb = 1'b0;
        Run  = 1'b0;
        #1;
        check("midrst_outputs", 32'(get_act()), 32'(mk(0,4'b0,4'b0,0,0,0,0,3'd0,0,2'd0,0)));
        check("midrst_ir", 32'(dut.r_ir), 32'd0);
        m_t  = 2'd0;
        m_ir = 10'd0;
        @(negedge CLKb);
        #1;
        CLRb = 1'b1;
        step_model("postrst_t0", 1'b1, 10'b0000_11_00_00);
        do_step("postrst_t1", 1'b0, 10'b0000_11_00_00, mk(0,4'b1000,4'b0000,1,0,0,0,3'd0,1,2'd1,0));

        // --- random instruction stream -----------------------------------
        n_instr = 0;
        steps   = 0;
        while (n_instr < 500 && steps < 5000) begin
            r_run   = ($urandom_range(0, 3) != 0);
            r_instr = 10'($urandom);
            if (m_t == 2'd0 && r_run) n_instr++;
            step_model("rand", r_run, r_instr);
            steps++;
        end
        check("rand_instr_count", 32'(n_instr), 32'd500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Control unit for the 10-bit processor. It latches an instruction word, steps it through timesteps T0–T3 using a 2-bit falling-edge timestep counter, and decodes instruction plus timestep into one-hot register, bus and ALU control strobes. It sits between the instruction source (INSTR/Run) and the datapath (register file, A/G registers, ALU, shared bus).

## Interface
Parameters:
- NREG, 4, number of general registers. Fixed at 4 because of the 2-bit register fields.

Ports:
- CLKb  in  1  clock. All state updates on the falling edge.
- CLRb  in  1  asynchronous active-low reset.
- Run  in  1  start request. Sampled only in T0.
- INSTR  in  10  instruction word. Fields: [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] unused.
- IRin  out  1  IR load strobe.
- Rin  out  4  one-hot register write enable.
- Rout  out  4  one-hot register bus drive.
- ExtOut  out  1  external data drives the bus.
- Ain  out  1  A register load.
- Gin  out  1  G register load.
- Gout  out  1  G drives the bus.
- ALUcont  out  3  ALU operation.
- Done  out  1  last timestep of the current instruction.
- Tstep  out  2  current timestep, for debug.

## Operation
- State:
  - IR[9:0].
  - T[1:0]. T0 = idle/fetch.
- Outputs are Moore-style combinational decode of (T, IR). Exception: IRin in T0 also depends on Run.
- T0:
  - IRin = Run.
  - If Run, then on the falling edge IR ← INSTR and T ← 1. Otherwise hold T0.
- Opcodes:
  - 0000 LD
    - T1: ExtOut, Rin[Rx], Done.
  - 0001 MOV
    - T1: Rout[Ry], Rin[Rx], Done.
  - 0010 ADD / 0011 SUB / 0100 AND / 0101 OR / 0110 XOR
    - T1: Rout[Rx], Ain.
    - T2: Rout[Ry], Gin, ALUcont = op.
    - T3: Gout, Rin[Rx], Done.
  - 0111 NOT
    - T1: Rout[Rx], Ain.
    - T2: Gin, ALUcont = NOT, no bus driver.
    - T3: Gout, Rin[Rx], Done.
  - 1000–1111 undefined
    - T1: Done only (NOP).
- Timestep advance:
  - Falling edge with Done = 1: T ← 0.
  - Otherwise, outside T0: T ← T+1.
  - T never wraps from T3 to T0 except through Done.
- Run is ignored in T1–T3. IR is stable from T1 until the next T0 load.
- Bus invariant: at most one of Rout[*], ExtOut, Gout is asserted in any timestep.
- ALUcont = 3'b000 whenever Gin = 0.
- Rx = Ry is legal. MOV R1,R1 asserts Rout[1] and Rin[1] together.

## Timing
- Reset (CLRb low, asynchronous, any timestep): T = 0, IR = 0. All outputs 0 except IRin = Run. Done = 0.
- Reset mid-instruction aborts it. No partial Rin pulse occurs after CLRb falls.
- Fetch latency: one falling edge from Run=1 in T0 to T1.
- Instruction length, including T0, in falling edges:
  - LD/MOV/undefined: 2.
  - ALU ops: 4.
- Done lasts exactly one timestep. The next instruction can be fetched on the edge after the one that returns T to T0.
- Run held high keeps the sequencer running back-to-back: T0 fetch follows every Done.

## Configuration
- Macro INSTR_SEQUENCER_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output ILL (1 bit).
  - For opcodes 1000–1111, T1 asserts ILL together with Done.
  - ILL is 0 in every other timestep and after reset.
- Undefined: the ILL port is absent and undefined opcodes behave as a silent NOP.

## Structure
- Shared package bitblaster_pkg holds:
  - opcode typedef enum logic [3:0] (LD, MOV, ADD, SUB, AND, OR, XOR, NOT).
  - ALU op typedef enum logic [2:0] (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5).
  - Instruction field bit-position constants.
- Sub-module tstep_counter:
  - 2-bit falling-edge counter with async active-low reset and synchronous clear/enable inputs.
  - The sequencer drives clear = Done and enable = (T≠0) | Run.
- Decode lives in the top as one combinational block.

## Test plan
- Reset with CLRb=0 in T2 of ADD → T=0, IR=0, Rin=0, Done=0 immediately. Run=1 after release fetches normally.
- LD R2 (INSTR=10'b0000_10_00_00), Run=1 → T1: ExtOut=1, Rin=4'b0100, Done=1. Next edge returns T0.
- SUB R1,R3 (10'b0011_01_11_00) → T1 Rout=0010,Ain; T2 Rout=1000,Gin,ALUcont=1; T3 Gout,Rin=0010,Done.
- Run toggled during T1–T3 of XOR → no effect, IR unchanged. Run held high → next instruction fetched on the edge after Done.
- Opcode 1010 → T1 Done=1, no Rin/Rout. ILL=1 only with INSTR_SEQUENCER_ILLEGAL_TRAP_EN.
- Random 500-instruction stream → bus one-hot-or-zero invariant holds every timestep. T never exceeds 3 without Done.
